// File: rtl/mestre_memoria_pkg.sv
// -----------------------------------------------------------------------------
// pacote_mem
// Shared definitions for the MEM-stage memory initiator:
//   - access size encodings carried on req_tamanho
//   - FSM state enumeration
//   - default memory depth in 32-bit words
// -----------------------------------------------------------------------------
package pacote_mem;

    localparam logic [1:0] TAM_BYTE    = 2'b00;
    localparam logic [1:0] TAM_MEIA    = 2'b01;
    localparam logic [1:0] TAM_PALAVRA = 2'b10;

    localparam int PROFUNDIDADE_PADRAO = 1501;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        LER       = 2'd1,
        ESCREVER  = 2'd2,
        RESPONDER = 2'd3
    } estado_t;

endpackage

// File: rtl/mestre_memoria_if.sv
// -----------------------------------------------------------------------------
// mestre_memoria_if
// Bundles the pipeline request/response handshake and the word-indexed memory
// block strobes seen by mestre_memoria.
//   modport master : the memory initiator (drives response, stall and memory
//                    strobes; receives requests and memSaida)
//   modport slave  : the surroundings (pipeline + memory block)
// -----------------------------------------------------------------------------
interface mestre_memoria_if;

    // Pipeline request side
    logic        req_valido;
    logic        req_pronto;
    logic        req_escrita;
    logic [1:0]  req_tamanho;
    logic        req_sem_sinal;
    logic [31:0] req_endereco;
    logic [31:0] req_dado;

    // Pipeline response side
    logic        resp_valido;
    logic [31:0] resp_dado;
    logic        resp_erro;
    logic        ocupado;

    // Memory block side
    logic [31:0] memEndereco;
    logic [31:0] memValor;
    logic        escreverMemoria;
    logic        lerMemoria;
    logic [31:0] memSaida;

    modport master (
        input  req_valido, req_escrita, req_tamanho, req_sem_sinal,
               req_endereco, req_dado, memSaida,
        output req_pronto, resp_valido, resp_dado, resp_erro, ocupado,
               memEndereco, memValor, escreverMemoria, lerMemoria
    );

    modport slave (
        output req_valido, req_escrita, req_tamanho, req_sem_sinal,
               req_endereco, req_dado, memSaida,
        input  req_pronto, resp_valido, resp_dado, resp_erro, ocupado,
               memEndereco, memValor, escreverMemoria, lerMemoria
    );

endinterface

// File: rtl/mestre_memoria_alinhador_dados.sv
// -----------------------------------------------------------------------------
// alinhador_dados (combinational)
// Little-endian lane handling for sub-word accesses.
//   tamanho_i          access size (byte / halfword / word)
//   sem_sinal_i        1 = zero-extend loads, 0 = sign-extend
//   desloc_i           byte offset inside the word (addr[1:0])
//   palavra_lida_i     word read from memory
//   dado_escrita_i     right-aligned store data
//   dado_carga_o       extracted and extended load result
//   palavra_mesclada_o read word with only the addressed lane replaced
// -----------------------------------------------------------------------------
module alinhador_dados
    import pacote_mem::*;
(
    input  logic [1:0]  tamanho_i,
    input  logic        sem_sinal_i,
    input  logic [1:0]  desloc_i,
    input  logic [31:0] palavra_lida_i,
    input  logic [31:0] dado_escrita_i,
    output logic [31:0] dado_carga_o,
    output logic [31:0] palavra_mesclada_o
);

    logic [7:0]  byte_s;
    logic [15:0] meia_s;

    // Select the addressed byte and halfword lanes of the read word
    always_comb begin
        byte_s = 8'h00;
        meia_s = 16'h0000;
        case (desloc_i)
            2'd0:    byte_s = palavra_lida_i[7:0];
            2'd1:    byte_s = palavra_lida_i[15:8];
            2'd2:    byte_s = palavra_lida_i[23:16];
            default: byte_s = palavra_lida_i[31:24];
        endcase
        if (desloc_i[1]) begin
            meia_s = palavra_lida_i[31:16];
        end else begin
            meia_s = palavra_lida_i[15:0];
        end
    end

    // Extend the selected lane to 32 bits; word loads pass straight through
    always_comb begin
        dado_carga_o = 32'h0000_0000;
        case (tamanho_i)
            TAM_BYTE: begin
                if (sem_sinal_i) begin
                    dado_carga_o = {24'h00_0000, byte_s};
                end else begin
                    dado_carga_o = {{24{byte_s[7]}}, byte_s};
                end
            end
            TAM_MEIA: begin
                if (sem_sinal_i) begin
                    dado_carga_o = {16'h0000, meia_s};
                end else begin
                    dado_carga_o = {{16{meia_s[15]}}, meia_s};
                end
            end
            TAM_PALAVRA: dado_carga_o = palavra_lida_i;
            default:     dado_carga_o = 32'h0000_0000;
        endcase
    end

    // Replace only the addressed lane with the low bits of the store data
    always_comb begin
        palavra_mesclada_o = palavra_lida_i;
        case (tamanho_i)
            TAM_BYTE: begin
                case (desloc_i)
                    2'd0:    palavra_mesclada_o[7:0]   = dado_escrita_i[7:0];
                    2'd1:    palavra_mesclada_o[15:8]  = dado_escrita_i[7:0];
                    2'd2:    palavra_mesclada_o[23:16] = dado_escrita_i[7:0];
                    default: palavra_mesclada_o[31:24] = dado_escrita_i[7:0];
                endcase
            end
            TAM_MEIA: begin
                if (desloc_i[1]) begin
                    palavra_mesclada_o[31:16] = dado_escrita_i[15:0];
                end else begin
                    palavra_mesclada_o[15:0] = dado_escrita_i[15:0];
                end
            end
            TAM_PALAVRA: palavra_mesclada_o = dado_escrita_i;
            default:     palavra_mesclada_o = palavra_lida_i;
        endcase
    end

endmodule

// File: rtl/mestre_memoria.sv
// -----------------------------------------------------------------------------
// mestre_memoria
// MEM-stage load/store initiator for the pipelined MIPS core. Accepts one
// request at a time over req_valido/req_pronto, drives the word-indexed memory
// block, performs read-modify-write for sub-word stores and returns a single
// resp_valido pulse per request. ocupado stalls the pipeline while busy.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus          : mestre_memoria_if.master (request, response, memory strobes)
//   PROFUNDIDADE     : memory size in words; larger word indices are errors
//   LATENCIA_LEITURA : cycles lerMemoria is held before memSaida is sampled (>=1)
// -----------------------------------------------------------------------------
module mestre_memoria
    import pacote_mem::*;
#(
    parameter int PROFUNDIDADE     = PROFUNDIDADE_PADRAO,
    parameter int LATENCIA_LEITURA = 1
) (
    input  logic              clock,
    input  logic              reset,
    mestre_memoria_if.master  bus
);

    localparam logic [31:0] LIMITE_INDICE   = 32'(PROFUNDIDADE);
    localparam logic [7:0]  ULTIMO_CICLO_LER = 8'(LATENCIA_LEITURA - 1);

    estado_t     estado_q;
    logic        escrita_q;
    logic [1:0]  tamanho_q;
    logic        sem_sinal_q;
    logic [1:0]  desloc_q;
    logic [31:0] dado_q;
    logic [7:0]  contador_q;

    logic        pronto_q;
    logic        ocupado_q;
    logic        resp_valido_q;
    logic [31:0] resp_dado_q;
    logic        resp_erro_q;
    logic [31:0] mem_endereco_q;
    logic [31:0] mem_valor_q;
    logic        escrever_q;
    logic        ler_q;

    logic [31:0] indice_s;
    logic        fora_faixa_s;
    logic        erro_req_s;
    logic [31:0] dado_carga_s;
    logic [31:0] palavra_mesclada_s;

    assign indice_s     = {2'b00, bus.req_endereco[31:2]};
    assign fora_faixa_s = (indice_s >= LIMITE_INDICE);

    // Classify the presented request: illegal size, misalignment or out of range
    always_comb begin
        erro_req_s = 1'b0;
        case (bus.req_tamanho)
            TAM_BYTE:    erro_req_s = fora_faixa_s;
            TAM_MEIA:    erro_req_s = fora_faixa_s | bus.req_endereco[0];
            TAM_PALAVRA: erro_req_s = fora_faixa_s | (|bus.req_endereco[1:0]);
            default:     erro_req_s = 1'b1;
        endcase
    end

    // Lane logic works on the captured request and the live memory read data
    alinhador_dados u_alinhador (
        .tamanho_i          (tamanho_q),
        .sem_sinal_i        (sem_sinal_q),
        .desloc_i           (desloc_q),
        .palavra_lida_i     (bus.memSaida),
        .dado_escrita_i     (dado_q),
        .dado_carga_o       (dado_carga_s),
        .palavra_mesclada_o (palavra_mesclada_s)
    );

    // Transaction FSM; every output is a register so reset drops strobes at once
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q       <= OCIOSO;
            escrita_q      <= 1'b0;
            tamanho_q      <= 2'b00;
            sem_sinal_q    <= 1'b0;
            desloc_q       <= 2'b00;
            dado_q         <= 32'h0000_0000;
            contador_q     <= 8'd0;
            pronto_q       <= 1'b1;
            ocupado_q      <= 1'b0;
            resp_valido_q  <= 1'b0;
            resp_dado_q    <= 32'h0000_0000;
            resp_erro_q    <= 1'b0;
            mem_endereco_q <= 32'h0000_0000;
            mem_valor_q    <= 32'h0000_0000;
            escrever_q     <= 1'b0;
            ler_q          <= 1'b0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (bus.req_valido && pronto_q) begin
                        escrita_q   <= bus.req_escrita;
                        tamanho_q   <= bus.req_tamanho;
                        sem_sinal_q <= bus.req_sem_sinal;
                        desloc_q    <= bus.req_endereco[1:0];
                        dado_q      <= bus.req_dado;
                        contador_q  <= 8'd0;
                        pronto_q    <= 1'b0;
                        ocupado_q   <= 1'b1;
                        if (erro_req_s) begin
                            // Rejected requests never touch the memory block
                            resp_valido_q <= 1'b1;
                            resp_erro_q   <= 1'b1;
                            resp_dado_q   <= 32'h0000_0000;
                            estado_q      <= RESPONDER;
                        end else begin
                            mem_endereco_q <= indice_s;
                            if (bus.req_escrita && (bus.req_tamanho == TAM_PALAVRA)) begin
                                mem_valor_q <= bus.req_dado;
                                escrever_q  <= 1'b1;
                                estado_q    <= ESCREVER;
                            end else begin
                                // Loads and sub-word stores both start by reading
                                ler_q    <= 1'b1;
                                estado_q <= LER;
                            end
                        end
                    end else begin
                        pronto_q  <= 1'b1;
                        ocupado_q <= 1'b0;
                    end
                end
                LER: begin
                    if (contador_q == ULTIMO_CICLO_LER) begin
                        ler_q <= 1'b0;
                        if (escrita_q) begin
                            mem_valor_q <= palavra_mesclada_s;
                            escrever_q  <= 1'b1;
                            estado_q    <= ESCREVER;
                        end else begin
                            resp_valido_q <= 1'b1;
                            resp_dado_q   <= dado_carga_s;
                            resp_erro_q   <= 1'b0;
                            estado_q      <= RESPONDER;
                        end
                    end else begin
                        contador_q <= contador_q + 8'd1;
                    end
                end
                ESCREVER: begin
                    escrever_q    <= 1'b0;
                    resp_valido_q <= 1'b1;
                    resp_dado_q   <= 32'h0000_0000;
                    resp_erro_q   <= 1'b0;
                    estado_q      <= RESPONDER;
                end
                RESPONDER: begin
                    resp_valido_q <= 1'b0;
                    resp_erro_q   <= 1'b0;
                    resp_dado_q   <= 32'h0000_0000;
                    pronto_q      <= 1'b1;
                    ocupado_q     <= 1'b0;
                    estado_q      <= OCIOSO;
                end
                default: begin
                    ler_q         <= 1'b0;
                    escrever_q    <= 1'b0;
                    resp_valido_q <= 1'b0;
                    resp_erro_q   <= 1'b0;
                    pronto_q      <= 1'b1;
                    ocupado_q     <= 1'b0;
                    estado_q      <= OCIOSO;
                end
            endcase
        end
    end

    assign bus.req_pronto      = pronto_q;
    assign bus.ocupado         = ocupado_q;
    assign bus.resp_valido     = resp_valido_q;
    assign bus.resp_dado       = resp_dado_q;
    assign bus.resp_erro       = resp_erro_q;
    assign bus.memEndereco     = mem_endereco_q;
    assign bus.memValor        = mem_valor_q;
    assign bus.escreverMemoria = escrever_q;
    assign bus.lerMemoria      = ler_q;

endmodule

// File: tb/tb_mestre_memoria.sv
// -----------------------------------------------------------------------------
// tb_mestre_memoria
// Drives mestre_memoria with a memory block model (word[i] = i at start),
// a table of directed transactions, a reset-in-flight sequence and random
// traffic checked against an arithmetic reference model of the memory.
// -----------------------------------------------------------------------------
module tb_mestre_memoria;
    import pacote_mem::*;

    localparam int PROF = 1501;

    logic clock = 1'b0;
    logic reset;
    logic mem_init;

    logic [31:0] mem     [0:PROF-1];
    logic [31:0] ref_mem [0:PROF-1];

    int verificacoes = 0;
    int erros        = 0;

    // Observations from the last transaction
    logic [31:0] obs_dado;
    logic        obs_erro;
    int          obs_ciclos;
    int          obs_ler;
    int          obs_escr;
    logic        obs_ambos;
    logic        obs_pronto_ruim;
    logic [31:0] obs_end;
    logic [31:0] obs_valor;
    logic        obs_pos_valido;
    logic        obs_pos_pronto;

    mestre_memoria_if bus ();

    mestre_memoria #(
        .PROFUNDIDADE     (PROF),
        .LATENCIA_LEITURA (1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Memory block model: combinational read, write on rising edge
    assign bus.memSaida = (bus.memEndereco < 32'(PROF)) ? mem[bus.memEndereco[10:0]] : 32'h0;

    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < PROF; i++) mem[i] <= 32'(i);
        end else if (bus.escreverMemoria && (bus.memEndereco < 32'(PROF))) begin
            mem[bus.memEndereco[10:0]] <= bus.memValor;
        end
    end

    task automatic comparar(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        verificacoes++;
        if (atual !== esperado) begin
            erros++;
            $display("FAIL %s: obtido 0x%08h esperado 0x%08h", nome, atual, esperado);
        end
    endtask

    task automatic ref_reinicia();
        for (int i = 0; i < PROF; i++) ref_mem[i] = 32'(i);
    endtask

    // Reference: memory as an array of words, lanes computed with plain arithmetic
    task automatic modelo(input logic esc, input logic [1:0] tam, input logic sem,
                          input logic [31:0] addr, input logic [31:0] dado,
                          output logic [31:0] e_dado, output logic e_erro, output int e_ciclos,
                          output int e_ler, output int e_escr, output logic [31:0] e_valor);
        longint unsigned indice, nbytes, desloc, mascara, palavra, v, a;
        a       = 64'(addr);
        indice  = a / 4;
        e_dado  = 32'h0;
        e_ciclos = 1;
        e_ler   = 0;
        e_escr  = 0;
        e_valor = 32'h0;
        e_erro  = (tam == 2'd3) || (indice >= 64'(PROF));
        nbytes  = (tam == 2'd3) ? 64'd1 : (64'd1 << tam);
        if (!e_erro && ((a % nbytes) != 64'd0)) e_erro = 1'b1;
        if (!e_erro) begin
            desloc  = 8 * (a % 4);
            mascara = (64'd1 << (8 * nbytes)) - 64'd1;
            palavra = 64'(ref_mem[indice[10:0]]);
            if (!esc) begin
                v = (palavra >> desloc) & mascara;
                if (!sem && (v > (mascara >> 1))) v = v + (64'hFFFF_FFFF - mascara);
                e_dado   = v[31:0];
                e_ciclos = 2;
                e_ler    = 1;
            end else begin
                v = (palavra & ~(mascara << desloc)) | ((64'(dado) & mascara) << desloc);
                ref_mem[indice[10:0]] = v[31:0];
                e_valor  = v[31:0];
                e_escr   = 1;
                e_ler    = (nbytes == 64'd4) ? 0 : 1;
                e_ciclos = (nbytes == 64'd4) ? 2 : 3;
            end
        end
    endtask

    task automatic executar(input logic esc, input logic [1:0] tam, input logic sem,
                            input logic [31:0] addr, input logic [31:0] dado);
        int espera;
        obs_dado = 32'h0; obs_erro = 1'b0; obs_ciclos = 0; obs_ler = 0; obs_escr = 0;
        obs_ambos = 1'b0; obs_pronto_ruim = 1'b0; obs_end = 32'hFFFF_FFFF; obs_valor = 32'h0;
        espera = 0;
        @(negedge clock);
        while (!bus.req_pronto && (espera < 10)) begin
            @(negedge clock);
            espera++;
        end
        if (!bus.req_pronto) begin
            verificacoes++;
            erros++;
            $display("FAIL aceitacao: req_pronto obtido 0 esperado 1");
        end
        bus.req_valido    = 1'b1;
        bus.req_escrita   = esc;
        bus.req_tamanho   = tam;
        bus.req_sem_sinal = sem;
        bus.req_endereco  = addr;
        bus.req_dado      = dado;
        @(posedge clock);
        #1;
        bus.req_valido = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            if (bus.lerMemoria) begin
                obs_ler++;
                obs_end = bus.memEndereco;
            end
            if (bus.escreverMemoria) begin
                obs_escr++;
                obs_end   = bus.memEndereco;
                obs_valor = bus.memValor;
            end
            if (bus.lerMemoria && bus.escreverMemoria) obs_ambos = 1'b1;
            if (bus.req_pronto || !bus.ocupado) obs_pronto_ruim = 1'b1;
            if (bus.resp_valido) begin
                obs_ciclos = c;
                obs_dado   = bus.resp_dado;
                obs_erro   = bus.resp_erro;
                break;
            end
        end
        if (obs_ciclos == 0) begin
            verificacoes++;
            erros++;
            $display("FAIL timeout resp_valido: obtido nenhum esperado pulso em 12 ciclos");
        end
        @(negedge clock);
        obs_pos_valido = bus.resp_valido;
        obs_pos_pronto = bus.req_pronto;
    endtask

    task automatic verificar(input string nome, input logic [31:0] e_dado, input logic e_erro,
                             input int e_ciclos, input int e_ler, input int e_escr,
                             input logic [31:0] e_end, input logic [31:0] e_valor);
        comparar({nome, " resp_dado"}, obs_dado, e_dado);
        comparar({nome, " resp_erro"}, 32'(obs_erro), 32'(e_erro));
        comparar({nome, " ciclo_resp"}, 32'(obs_ciclos), 32'(e_ciclos));
        comparar({nome, " ciclos_ler"}, 32'(obs_ler), 32'(e_ler));
        comparar({nome, " ciclos_escrever"}, 32'(obs_escr), 32'(e_escr));
        comparar({nome, " strobes_juntos"}, 32'(obs_ambos), 32'd0);
        comparar({nome, " pronto_ocupado"}, 32'(obs_pronto_ruim), 32'd0);
        comparar({nome, " pulso_unico"}, 32'(obs_pos_valido), 32'd0);
        comparar({nome, " pronto_apos"}, 32'(obs_pos_pronto), 32'd1);
        if ((e_ler + e_escr) > 0) comparar({nome, " memEndereco"}, obs_end, e_end);
        if (e_escr > 0) comparar({nome, " memValor"}, obs_valor, e_valor);
    endtask

    typedef struct {
        logic        esc;
        logic [1:0]  tam;
        logic        sem;
        logic [31:0] addr;
        logic [31:0] dado;
        logic [31:0] exp_dado;
        logic        exp_erro;
        int          exp_ciclos;
        int          exp_ler;
        int          exp_escr;
        logic [31:0] exp_valor;
    } vetor_t;

    vetor_t tabela [17];

    initial begin
        logic [31:0] m_dado, m_valor, addr, dado;
        logic        m_erro, esc, sem, flag;
        logic [1:0]  tam;
        int          m_ciclos, m_ler, m_escr, r;

        tabela[0]  = '{1'b0, 2'b10, 1'b0, 32'h14,   32'h0,        32'h0000_0005, 1'b0, 2, 1, 0, 32'h0};
        tabela[1]  = '{1'b1, 2'b10, 1'b0, 32'h20,   32'hDEADBEEF, 32'h0,         1'b0, 2, 0, 1, 32'hDEADBEEF};
        tabela[2]  = '{1'b1, 2'b00, 1'b0, 32'h15,   32'h0000_00AB, 32'h0,        1'b0, 3, 1, 1, 32'h0000_AB05};
        tabela[3]  = '{1'b0, 2'b10, 1'b0, 32'h14,   32'h0,        32'h0000_AB05, 1'b0, 2, 1, 0, 32'h0};
        tabela[4]  = '{1'b0, 2'b00, 1'b0, 32'h15,   32'h0,        32'hFFFF_FFAB, 1'b0, 2, 1, 0, 32'h0};
        tabela[5]  = '{1'b0, 2'b00, 1'b1, 32'h15,   32'h0,        32'h0000_00AB, 1'b0, 2, 1, 0, 32'h0};
        tabela[6]  = '{1'b0, 2'b01, 1'b0, 32'h16,   32'h0,        32'h0000_0000, 1'b0, 2, 1, 0, 32'h0};
        tabela[7]  = '{1'b0, 2'b01, 1'b0, 32'h13,   32'h0,        32'h0,         1'b1, 1, 0, 0, 32'h0};
        tabela[8]  = '{1'b0, 2'b10, 1'b0, 32'h1774, 32'h0,        32'h0,         1'b1, 1, 0, 0, 32'h0};
        tabela[9]  = '{1'b0, 2'b11, 1'b0, 32'h14,   32'h0,        32'h0,         1'b1, 1, 0, 0, 32'h0};
        tabela[10] = '{1'b0, 2'b10, 1'b0, 32'h20,   32'h0,        32'hDEADBEEF,  1'b0, 2, 1, 0, 32'h0};
        tabela[11] = '{1'b1, 2'b01, 1'b0, 32'h1A,   32'h1234_8001, 32'h0,        1'b0, 3, 1, 1, 32'h8001_0006};
        tabela[12] = '{1'b0, 2'b01, 1'b0, 32'h1A,   32'h0,        32'hFFFF_8001, 1'b0, 2, 1, 0, 32'h0};
        tabela[13] = '{1'b0, 2'b01, 1'b1, 32'h1A,   32'h0,        32'h0000_8001, 1'b0, 2, 1, 0, 32'h0};
        tabela[14] = '{1'b1, 2'b00, 1'b0, 32'h17,   32'hFFFF_FF7E, 32'h0,        1'b0, 3, 1, 1, 32'h7E00_AB05};
        tabela[15] = '{1'b1, 2'b10, 1'b0, 32'h22,   32'h0000_0055, 32'h0,        1'b1, 1, 0, 0, 32'h0};
        tabela[16] = '{1'b0, 2'b00, 1'b0, 32'h17,   32'h0,        32'h0000_007E, 1'b0, 2, 1, 0, 32'h0};

        reset = 1'b1;
        mem_init = 1'b1;
        bus.req_valido = 1'b0; bus.req_escrita = 1'b0; bus.req_tamanho = 2'b00;
        bus.req_sem_sinal = 1'b0; bus.req_endereco = 32'h0; bus.req_dado = 32'h0;
        ref_reinicia();
        repeat (3) @(posedge clock);
        @(negedge clock);
        comparar("reset req_pronto", 32'(bus.req_pronto), 32'd1);
        comparar("reset ocupado", 32'(bus.ocupado), 32'd0);
        comparar("reset resp_valido", 32'(bus.resp_valido), 32'd0);
        comparar("reset resp_erro", 32'(bus.resp_erro), 32'd0);
        comparar("reset resp_dado", bus.resp_dado, 32'd0);
        comparar("reset memEndereco", bus.memEndereco, 32'd0);
        comparar("reset memValor", bus.memValor, 32'd0);
        comparar("reset strobes", {30'd0, bus.lerMemoria, bus.escreverMemoria}, 32'd0);
        reset = 1'b0;
        mem_init = 1'b0;

        // Directed table
        for (int i = 0; i < 17; i++) begin
            executar(tabela[i].esc, tabela[i].tam, tabela[i].sem, tabela[i].addr, tabela[i].dado);
            verificar($sformatf("tabela[%0d]", i), tabela[i].exp_dado, tabela[i].exp_erro,
                      tabela[i].exp_ciclos, tabela[i].exp_ler, tabela[i].exp_escr,
                      tabela[i].addr >> 2, tabela[i].exp_valor);
            modelo(tabela[i].esc, tabela[i].tam, tabela[i].sem, tabela[i].addr, tabela[i].dado,
                   m_dado, m_erro, m_ciclos, m_ler, m_escr, m_valor);
        end

        // Reset during the read phase of a byte store
        @(negedge clock);
        while (!bus.req_pronto) @(negedge clock);
        bus.req_valido = 1'b1; bus.req_escrita = 1'b1; bus.req_tamanho = 2'b00;
        bus.req_sem_sinal = 1'b0; bus.req_endereco = 32'h15; bus.req_dado = 32'h11;
        @(posedge clock);
        #1;
        bus.req_valido = 1'b0;
        @(negedge clock);
        comparar("rst lerMemoria antes", 32'(bus.lerMemoria), 32'd1);
        #2;
        reset = 1'b1;
        mem_init = 1'b1;
        #1;
        comparar("rst lerMemoria assincrono", 32'(bus.lerMemoria), 32'd0);
        comparar("rst ocupado assincrono", 32'(bus.ocupado), 32'd0);
        flag = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (bus.escreverMemoria || bus.resp_valido || bus.lerMemoria) flag = 1'b1;
        end
        reset = 1'b0;
        mem_init = 1'b0;
        ref_reinicia();
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            if (bus.escreverMemoria || bus.resp_valido) flag = 1'b1;
        end
        comparar("rst sem atividade", 32'(flag), 32'd0);
        comparar("rst req_pronto", 32'(bus.req_pronto), 32'd1);
        executar(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        verificar("rst carga_palavra", 32'h5, 1'b0, 2, 1, 0, 32'd5, 32'h0);
        comparar("rst mem[5]", mem[5], 32'h5);

        // Random traffic against the reference model
        for (int n = 0; n < 150; n++) begin
            esc = 1'($urandom_range(0, 1));
            sem = 1'($urandom_range(0, 1));
            r   = $urandom_range(0, 9);
            tam = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            r   = $urandom_range(0, 9);
            if (r == 0) begin
                addr = (32'($urandom_range(1499, 1502)) << 2) | 32'($urandom_range(0, 3));
            end else if (r == 1) begin
                addr = $urandom();
            end else begin
                addr = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
                if (r >= 5) begin
                    if (tam == 2'b01) addr[0] = 1'b0;
                    if (tam == 2'b10) addr[1:0] = 2'b00;
                end
            end
            dado = $urandom();
            modelo(esc, tam, sem, addr, dado, m_dado, m_erro, m_ciclos, m_ler, m_escr, m_valor);
            executar(esc, tam, sem, addr, dado);
            verificar($sformatf("aleatorio[%0d]", n), m_dado, m_erro, m_ciclos, m_ler, m_escr,
                      addr >> 2, m_valor);
            if (m_escr > 0) comparar($sformatf("aleatorio[%0d] memoria", n),
                                     mem[addr[12:2]], ref_mem[addr[12:2]]);
        end

        $display("CHECKS %0d ERRORS %0d", verificacoes, erros);
        $finish;
    end

endmodule
